// File: rtl/divider_mc_if.sv
// rtl/divider_mc_if.sv - E-stage handshake bundle for the multi-cycle divider
// Ports:
//   master modport (pipeline side): drives div_en, div_sign, div_a, div_b,
//                                   e_hold, e_flush; receives div_ready, div_lo, div_hi
//   slave modport (divider side):   the mirror image
interface divider_mc_if #(
   parameter int WIDTH = 32
);
   logic             div_en;
   logic             div_sign;
   logic [WIDTH-1:0] div_a;
   logic [WIDTH-1:0] div_b;
   logic             e_hold;
   logic             e_flush;
   logic             div_ready;
   logic [WIDTH-1:0] div_lo;
   logic [WIDTH-1:0] div_hi;

   modport master (
      output div_en, div_sign, div_a, div_b, e_hold, e_flush,
      input  div_ready, div_lo, div_hi
   );

   modport slave (
      input  div_en, div_sign, div_a, div_b, e_hold, e_flush,
      output div_ready, div_lo, div_hi
   );
endinterface

// File: rtl/divider_mc.sv
// rtl/divider_mc.sv - 32-cycle restoring divider (DIV/DIVU) for the E stage
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - divider_mc_if.slave: div_en/div_sign/div_a/div_b start a divide,
//          e_hold keeps a finished result, e_flush kills the operation,
//          div_ready/div_lo/div_hi are the registered result (quotient/remainder)
module divider_mc #(
   parameter int WIDTH = 32
) (
   input  logic         clk,
   input  logic         rst,
   divider_mc_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state;
   logic [4:0]       cnt;
   logic [WIDTH:0]   rem;       // partial remainder, one bit wider than operands
   logic [WIDTH-1:0] quo;       // dividend shifts out MSB-first, quotient bits shift in
   logic [WIDTH-1:0] dvs;       // divisor magnitude
   logic             sgn;
   logic             sign_a;
   logic             sign_b;
   logic             ready_q;
   logic [WIDTH-1:0] lo_q;
   logic [WIDTH-1:0] hi_q;

   // Operand magnitudes for capture at start
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;

   // One restoring step
   logic [WIDTH+1:0] trial;
   logic             fits;
   logic [WIDTH:0]   rem_nxt;
   logic [WIDTH-1:0] quo_nxt;
   logic             neg_q;
   logic             neg_r;

   always_comb begin
      a_neg = bus.div_sign & bus.div_a[WIDTH-1];
      b_neg = bus.div_sign & bus.div_b[WIDTH-1];
      a_mag = a_neg ? -bus.div_a : bus.div_a;
      b_mag = b_neg ? -bus.div_b : bus.div_b;

      // rem < divisor always, so {rem, next bit} < 2^(WIDTH+1); the extra top
      // bit of trial is therefore a clean borrow flag.
      trial   = {rem, quo[WIDTH-1]} - {2'b00, dvs};
      fits    = ~trial[WIDTH+1];
      rem_nxt = fits ? trial[WIDTH:0] : {rem[WIDTH-1:0], quo[WIDTH-1]};
      quo_nxt = {quo[WIDTH-2:0], fits};

      neg_q = sgn & (sign_a ^ sign_b);
      neg_r = sgn & sign_a;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= 5'd0;
         rem     <= '0;
         quo     <= '0;
         dvs     <= '0;
         sgn     <= 1'b0;
         sign_a  <= 1'b0;
         sign_b  <= 1'b0;
         ready_q <= 1'b0;
         lo_q    <= '0;
         hi_q    <= '0;
      end else if (bus.e_flush) begin
         // Flush beats start and DONE hold; last results stay visible
         state   <= IDLE;
         ready_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.div_en) begin
                  state  <= BUSY;
                  cnt    <= 5'd0;
                  rem    <= '0;
                  quo    <= a_mag;
                  dvs    <= b_mag;
                  sgn    <= bus.div_sign;
                  sign_a <= bus.div_a[WIDTH-1];
                  sign_b <= bus.div_b[WIDTH-1];
               end
            end
            BUSY: begin
               // div_en dropping here does not abort; downstream ignores the result
               cnt <= cnt + 5'd1;
               rem <= rem_nxt;
               quo <= quo_nxt;
               if (cnt == 5'd31) begin
                  state   <= DONE;
                  ready_q <= 1'b1;
                  lo_q    <= neg_q ? -quo_nxt : quo_nxt;
                  hi_q    <= neg_r ? -rem_nxt[WIDTH-1:0] : rem_nxt[WIDTH-1:0];
               end
            end
            DONE: begin
               if (!bus.e_hold) begin
                  state   <= IDLE;
                  ready_q <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.div_ready = ready_q;
   assign bus.div_lo    = lo_q;
   assign bus.div_hi    = hi_q;

endmodule

// File: tb/tb_divider_mc.sv
// tb/tb_divider_mc.sv - directed self-checking bench for divider_mc
module tb_divider_mc;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   divider_mc_if #(.WIDTH(32)) bus ();

   divider_mc #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Called at #1 after a rising edge. Starts a divide, scrambles operands
   // mid-operation, counts edges until div_ready and checks the result.
   task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [31:0] exp_lo,
                          input logic [31:0] exp_hi, input int exp_lat);
      int lat;
      bus.div_en   = 1'b1;
      bus.div_a    = a;
      bus.div_b    = b;
      bus.div_sign = s;
      lat = 0;
      for (int i = 1; i <= 60; i++) begin
         @(posedge clk);
         #1;
         if (i == 3) begin
            bus.div_a    = 32'hA5A5_1234;
            bus.div_b    = 32'h0000_0003;
            bus.div_sign = ~s;
         end
         if (bus.div_ready) begin
            lat = i;
            break;
         end
      end
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check({tag, "_lo"}, bus.div_lo, exp_lo);
      check({tag, "_hi"}, bus.div_hi, exp_hi);
   endtask

   task automatic release_div(input string tag);
      bus.div_en = 1'b0;
      bus.e_hold = 1'b0;
      @(posedge clk);
      #1;
      check({tag, "_rdy_off"}, {31'd0, bus.div_ready}, 32'd0);
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      rst          = 1'b1;
      bus.div_en   = 1'b0;
      bus.div_sign = 1'b0;
      bus.div_a    = '0;
      bus.div_b    = '0;
      bus.e_hold   = 1'b0;
      bus.e_flush  = 1'b0;
      @(posedge clk);
      #1;
      check("rst_rdy", {31'd0, bus.div_ready}, 32'd0);
      check("rst_lo", bus.div_lo, 32'd0);
      check("rst_hi", bus.div_hi, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      run_div("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 33);
      release_div("u100_7");
      run_div("sm7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
      release_div("sm7_2");
      run_div("s7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 33);
      release_div("s7_m2");
      run_div("smin_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 33);
      release_div("smin_m1");
      run_div("u5_0", 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 33);
      release_div("u5_0");
      run_div("sm5_0", 32'hFFFF_FFFB, 32'd0, 1'b1, 32'd1, 32'hFFFF_FFFB, 33);
      release_div("sm5_0");
      run_div("ubig", 32'hFFFF_FFFF, 32'd16, 1'b0, 32'h0FFF_FFFF, 32'd15, 33);
      release_div("ubig");

      // Flush in BUSY cycle 10: results from "ubig" must survive
      bus.div_en   = 1'b1;
      bus.div_a    = 32'd1000;
      bus.div_b    = 32'd3;
      bus.div_sign = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk);
         #1;
         check("flush_busy_rdy", {31'd0, bus.div_ready}, 32'd0);
      end
      bus.e_flush = 1'b1;
      bus.div_en  = 1'b0;
      @(posedge clk);
      #1;
      bus.e_flush = 1'b0;
      check("flush_rdy", {31'd0, bus.div_ready}, 32'd0);
      check("flush_lo_kept", bus.div_lo, 32'h0FFF_FFFF);
      check("flush_hi_kept", bus.div_hi, 32'd15);
      @(posedge clk);
      #1;
      check("flush_idle_rdy", {31'd0, bus.div_ready}, 32'd0);
      run_div("u20_4", 32'd20, 32'd4, 1'b0, 32'd5, 32'd0, 33);
      release_div("u20_4");

      // DONE held by e_hold for 5 cycles
      bus.e_hold = 1'b1;
      run_div("hold", 32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, 33);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("hold_rdy", {31'd0, bus.div_ready}, 32'd1);
         check("hold_lo", bus.div_lo, 32'd333);
         check("hold_hi", bus.div_hi, 32'd1);
      end
      release_div("hold");

      // Back-to-back: div_en stays high across DONE -> 34 cycles apart
      run_div("b2b_first", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 33);
      run_div("b2b_second", 32'd99, 32'd10, 1'b0, 32'd9, 32'd9, 34);
      release_div("b2b");

      // Async reset mid-BUSY, between clock edges
      bus.div_en   = 1'b1;
      bus.div_a    = 32'd50;
      bus.div_b    = 32'd5;
      bus.div_sign = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk);
         #1;
      end
      #2;
      rst = 1'b1;
      #1;
      check("arst_rdy", {31'd0, bus.div_ready}, 32'd0);
      check("arst_lo", bus.div_lo, 32'd0);
      check("arst_hi", bus.div_hi, 32'd0);
      bus.div_en = 1'b0;
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("arst_idle_rdy", {31'd0, bus.div_ready}, 32'd0);
      run_div("u50_5", 32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 33);
      release_div("u50_5");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
